// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: dump sequencer state encoding and the
// default readback layout (32 GPRs, PC, 7 pipeline latch words).
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SEND   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_CKSUM  = 3'd5,
    ST_FINISH = 3'd6
  } dump_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  localparam int unsigned N_GPR_WORDS   = 32;
  localparam int unsigned N_PC_WORDS    = 1;
  localparam int unsigned N_LATCH_WORDS = 7;
  localparam int unsigned N_DUMP_WORDS  = N_GPR_WORDS + N_PC_WORDS + N_LATCH_WORDS;

endpackage

// File: rtl/dump_sequencer_word_serializer.sv
// Loadable word shift register with a byte counter; emits bytes MSB first.
// cur_byte is the byte that becomes current at the coming clock edge, so the
// sequencer can register it into tx_data in the same cycle it loads/shifts.
module word_serializer
  import debug_pkg::*;
#(
  parameter int unsigned NB_DATA = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [NB_DATA-1:0] din,
  output logic [7:0]         cur_byte,
  output logic               last_byte
);

  logic [NB_DATA-1:0] shift_q;
  logic [1:0]         byte_cnt;

  // Load a fresh word or advance by one byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shift_q  <= din;
      byte_cnt <= '0;
    end else if (shift) begin
      shift_q  <= {shift_q[NB_DATA-9:0], 8'h00};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Look-ahead byte selection matching the pending load/shift.
  always_comb begin
    cur_byte = shift_q[NB_DATA-1 -: 8];
    if (load)
      cur_byte = din[NB_DATA-1 -: 8];
    else if (shift)
      cur_byte = shift_q[NB_DATA-9 -: 8];
  end

  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/dump_sequencer.sv
// Debug dump sequencer: walks N_WORDS readback words and streams each one
// big-endian, byte by byte, through the UART tx_start/tx_done_tick handshake.
// Optional feature macro: DUMP_CHECKSUM_EN appends an 8-bit XOR of all bytes.
module dump_sequencer
  import debug_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 6,
  parameter int unsigned N_WORDS = N_DUMP_WORDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [NB_ADDR-1:0] rd_addr,
  input  logic [NB_DATA-1:0] rd_data,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_done_tick,
  output logic               busy,
  output logic               done
);

  localparam logic [NB_ADDR-1:0] LAST_WORD = NB_ADDR'(N_WORDS - 1);

  dump_state_t        state;
  logic [NB_ADDR-1:0] word_idx;
  logic               ser_load;
  logic               ser_shift;
  logic [7:0]         ser_byte;
  logic               ser_last;

`ifdef DUMP_CHECKSUM_EN
  logic [7:0]         csum;
  logic               csum_sent;
`endif

  // word_idx is a register, so the readback address stays a registered output.
  assign rd_addr   = word_idx;
  assign ser_load  = (state == ST_LOAD);
  assign ser_shift = (state == ST_WAIT) && tx_done_tick && !ser_last;

  word_serializer #(
    .NB_DATA (NB_DATA)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .shift     (ser_shift),
    .din       (rd_data),
    .cur_byte  (ser_byte),
    .last_byte (ser_last)
  );

  // Dump FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      word_idx  <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum      <= '0;
      csum_sent <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            busy     <= 1'b1;
            word_idx <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum      <= '0;
            csum_sent <= 1'b0;
`endif
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          state    <= ST_SEND;
          tx_start <= 1'b1;
          tx_data  <= ser_byte;
`ifdef DUMP_CHECKSUM_EN
          csum <= csum ^ ser_byte;
`endif
        end
        ST_SEND: state <= ST_WAIT;
        ST_WAIT: begin
          if (tx_done_tick) begin
`ifdef DUMP_CHECKSUM_EN
            if (csum_sent) begin
              state <= ST_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else
`endif
            if (!ser_last) begin
              state    <= ST_SEND;
              tx_start <= 1'b1;
              tx_data  <= ser_byte;
`ifdef DUMP_CHECKSUM_EN
              csum <= csum ^ ser_byte;
`endif
            end else if (word_idx != LAST_WORD) begin
              word_idx <= word_idx + 1'b1;
              state    <= ST_FETCH;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              state     <= ST_CKSUM;
              tx_start  <= 1'b1;
              tx_data   <= csum;
              csum_sent <= 1'b1;
`else
              state <= ST_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        ST_CKSUM: state <= ST_WAIT;
`endif
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dump_sequencer.sv
// Self-checking bench for dump_sequencer: randomized word contents, UART
// latency and noise (stray start / tick pulses) against a byte-stream model.
module tb_dump_sequencer;

  localparam int unsigned NW = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done_tick;
  logic        busy;
  logic        done;

  logic        uart_tick = 1'b0;
  logic        noise_send = 1'b0;
  logic        noise_fetch = 1'b0;
  int unsigned uart_delay = 5;
  bit          noise_en = 1'b0;
  int unsigned uart_cnt = 0;

  logic [31:0] mem [0:63];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // monitor records
  logic [7:0]  got_bytes [$];
  int          tx_cyc [$];
  int          gaps [$];
  int          addr_q [$];
  int          busy_low_at_tx = 0;
  int          done_cnt = 0;
  int          done_gap = 0;
  int          busy_at_done = 0;
  int          dbl_cnt = 0;
  int          last_tick_cyc = 0;
  logic        prev_tx_start = 1'b0;

  logic [7:0]  exp_bytes [$];

  assign tx_done_tick = uart_tick | noise_send | noise_fetch;

  dump_sequencer #(
    .NB_DATA (32),
    .NB_ADDR (6),
    .N_WORDS (NW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // readback source: synchronous, one cycle of latency
  always @(posedge clk) rd_data <= mem[rd_addr];

  // UART model: tick uart_delay cycles after each tx_start; optional stray
  // tick during the SEND cycle itself
  always @(posedge clk) begin
    #1;
    uart_tick  = 1'b0;
    noise_send = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt = uart_cnt - 1;
      if (uart_cnt == 0) uart_tick = 1'b1;
    end
    if (tx_start) begin
      uart_cnt = uart_delay;
      if (noise_en) noise_send = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (uart_tick) last_tick_cyc = cyc;
    if (tx_start) begin
      got_bytes.push_back(tx_data);
      tx_cyc.push_back(cyc);
      gaps.push_back(cyc - last_tick_cyc);
      addr_q.push_back(int'(rd_addr));
      if (!busy) busy_low_at_tx++;
    end
    if (done) begin
      done_cnt++;
      done_gap = cyc - last_tick_cyc;
      busy_at_done = int'(busy);
    end
    if (tx_start && prev_tx_start) dbl_cnt++;
    prev_tx_start = tx_start;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // expected stream: every word big-endian, then (optionally) XOR of all bytes
  task automatic build_expected();
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    exp_bytes.delete();
    for (int i = 0; i < int'(NW); i++) begin
      w = mem[i];
      for (int b = 0; b < 4; b++) begin
        exp_bytes.push_back(w[31 - 8*b -: 8]);
        x = x ^ w[31 - 8*b -: 8];
      end
    end
`ifdef DUMP_CHECKSUM_EN
    exp_bytes.push_back(x);
`endif
  endtask

  task automatic run_dump(input int unsigned dly, input bit noisy);
    int s;
    int guard;
    bit seen;
    int exp_gap;
    build_expected();
    got_bytes.delete();
    tx_cyc.delete();
    gaps.delete();
    addr_q.delete();
    busy_low_at_tx = 0;
    done_cnt = 0;
    dbl_cnt = 0;
    uart_delay = dly;
    noise_en = noisy;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    if (noisy) noise_fetch = 1'b1;
    check_eq("busy_in_fetch", busy, 1'b1);
    check_eq("rd_addr_fetch", rd_addr, 0);
    @(negedge clk);
    noise_fetch = 1'b0;
    guard = 0;
    seen = 1'b0;
    while (!seen && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (done) seen = 1'b1;
      else if (noisy) start = ($urandom_range(0, 5) == 0);
    end
    start = 1'b0;
    if (!seen) check_eq("done_timeout", 0, 1);
    repeat (3) @(negedge clk);

    check_eq("byte_count", got_bytes.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      check_eq($sformatf("byte%0d", i), got_bytes[i], exp_bytes[i]);
      if (i == 0) begin
        check_eq("first_latency", tx_cyc[0] - s, 3);
      end else begin
        exp_gap = ((i % 4 == 0) && (i < 4 * int'(NW))) ? 3 : 1;
        check_eq($sformatf("gap%0d", i), gaps[i], exp_gap);
      end
      if (i < 4 * int'(NW))
        check_eq($sformatf("addr%0d", i), addr_q[i], i / 4);
    end
    check_eq("busy_low_at_tx", busy_low_at_tx, 0);
    check_eq("done_count", done_cnt, 1);
    check_eq("done_gap", done_gap, 1);
    check_eq("busy_at_done", busy_at_done, 0);
    check_eq("tx_start_back2back", dbl_cnt, 0);
    check_eq("busy_after", busy, 1'b0);
  endtask

  task automatic reset_mid_dump();
    bit found;
    uart_delay = 5;
    noise_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (tx_start) found = 1'b1;
    end
    check_eq("rst_reach_send", found, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_async_tx_start", tx_start, 1'b0);
    check_eq("rst_async_busy", busy, 1'b0);
    check_eq("rst_async_tx_data", tx_data, 8'h00);
    check_eq("rst_async_done", done, 1'b0);
    got_bytes.delete();
    done_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rst_no_more_tx", got_bytes.size(), 0);
    check_eq("rst_no_done", done_cnt, 0);
    check_eq("rst_idle_busy", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_tx_start", tx_start, 1'b0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_tx_start", tx_start, 1'b0);
    check_eq("idle_done", done, 1'b0);

    mem[0] = 32'hDEADBEEF;
    run_dump(5, 1'b0);

    mem[0] = 32'h01020304;
    mem[1] = 32'h05060708;
    run_dump(3, 1'b0);
    run_dump(2, 1'b1);

    for (int k = 0; k < 6; k++) begin
      mem[0] = $urandom;
      mem[1] = $urandom;
      run_dump($urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end

    reset_mid_dump();
    mem[0] = $urandom;
    run_dump(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
